// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard and flush controller for a 5-stage pipeline that has no operand
//   forwarding. A small scoreboard follows the destination registers of
//   instructions that are still in flight (ID/EX .. MEM/WR). An ID-stage
//   instruction that reads one of those registers is held (stall) and
//   replaced by a bubble until the producer has written back. A taken
//   branch or jump holds flush high for FLUSH_CYCLES cycles, which clears
//   the IF/ID register.
//
// Parameters
//   DEPTH        in-flight writeback stages tracked (entry 0 = ID/EX)
//   FLUSH_CYCLES cycles flush stays high after an accepted branch (1..7)
//   CNT_W        width of the saturating stall-cycle counter
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   id_valid                 instruction present in ID
//   id_rs, id_rt             source register addresses
//   id_uses_rs, id_uses_rt   the instruction actually reads that source
//   id_regwr, id_aw          the instruction writes register id_aw
//   branch_taken             redirect request from ID/EX
//   stall, bubble            hold PC and IF/ID / zero the ID/EX controls
//   flush                    clear IF/ID (registered)
//   stall_cnt                stall cycles since reset, saturating
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int DEPTH        = 3,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_regwr,
   input  logic [4:0]       id_aw,
   input  logic             branch_taken,
   output logic             stall,
   output logic             bubble,
   output logic             flush,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   // Scoreboard storage
   logic [DEPTH-1:0]      vld_reg;
   logic [DEPTH-1:0][4:0] aw_reg;
   logic [DEPTH-1:0]      vld_next;
   logic [DEPTH-1:0][4:0] aw_next;
   logic [DEPTH-1:0]      match;

   state_t     state_reg, state_next;
   logic [2:0] fcnt_reg, fcnt_next;
   logic [CNT_W-1:0] stall_cnt_reg;

   logic hazard;
   logic issue;
   logic rs_live;
   logic rt_live;

   // $0 is hard-wired, so it is never a real dependency.
   assign rs_live = id_uses_rs & (id_rs != 5'd0);
   assign rt_live = id_uses_rt & (id_rt != 5'd0);

   assign flush  = (state_reg == FLUSH);
   // Flush masks the hazard: the instruction in ID is being discarded anyway,
   // which also guarantees stall and flush are never high together.
   assign hazard = id_valid & ~flush & (|match);
   assign stall  = hazard;
   assign bubble = hazard;

   assign issue = id_valid & ~stall & ~flush & id_regwr & (id_aw != 5'd0);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_sb
         assign match[gi] = vld_reg[gi] &
                            ((rs_live & (aw_reg[gi] == id_rs)) |
                             (rt_live & (aw_reg[gi] == id_rt)));
         if (gi == 0) begin : g_head
            assign vld_next[gi] = issue;
            assign aw_next[gi]  = issue ? id_aw : 5'd0;
         end else begin : g_tail
            // Plain shift: entries move one stage per cycle whether or not
            // the front end stalls, and are never cancelled by flush.
            assign vld_next[gi] = vld_reg[gi-1];
            assign aw_next[gi]  = aw_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_reg <= '0;
         aw_reg  <= '0;
      end else begin
         vld_reg <= vld_next;
         aw_reg  <= aw_next;
      end
   end

   // Flush FSM
   always_comb begin
      state_next = state_reg;
      fcnt_next  = fcnt_reg;
      case (state_reg)
         RUN: begin
            // A branch seen during a stall is dropped; its source repeats it.
            if (branch_taken & ~stall) begin
               state_next = FLUSH;
               fcnt_next  = FLUSH_LOAD;
            end
         end
         FLUSH: begin
            if (branch_taken & ~stall) begin
               fcnt_next = FLUSH_LOAD;
            end else if (fcnt_reg == 3'd0) begin
               state_next = RUN;
            end else begin
               fcnt_next = fcnt_reg - 3'd1;
            end
         end
         default: begin
            state_next = RUN;
            fcnt_next  = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= RUN;
         fcnt_reg  <= 3'd0;
      end else begin
         state_reg <= state_next;
         fcnt_reg  <= fcnt_next;
      end
   end

   // Saturating stall-cycle counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_reg <= '0;
      end else if (stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
         stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed table of per-cycle ID inputs with hand-computed stall/flush and
//   stall-counter values, followed by hand-written reset sequences. A second
//   instance with a 2-bit counter shares every input so counter saturation
//   is observed without waiting 65535 stall cycles.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs, id_rt, id_aw;
   logic       id_uses_rs, id_uses_rt, id_regwr;
   logic       branch_taken;

   logic        stall, bubble, flush;
   logic [15:0] stall_cnt;
   logic        stall2, bubble2, flush2;
   logic [1:0]  stall_cnt2;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.DEPTH(3), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwr(id_regwr),
      .id_aw(id_aw), .branch_taken(branch_taken), .stall(stall),
      .bubble(bubble), .flush(flush), .stall_cnt(stall_cnt)
   );

   pipe_hazard_ctrl #(.DEPTH(3), .FLUSH_CYCLES(2), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwr(id_regwr),
      .id_aw(id_aw), .branch_taken(branch_taken), .stall(stall2),
      .bubble(bubble2), .flush(flush2), .stall_cnt(stall_cnt2)
   );

   typedef struct {
      logic       v;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic       rw;
      logic [4:0] aw;
      logic       br;
      logic       e_stall;
      logic       e_flush;
      int         e_cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic v, input int rs, input int rt, input logic urs,
                      input logic urt, input logic rw, input int aw, input logic br,
                      input logic es, input logic ef, input int ec);
      vec_t t;
      t.v = v; t.rs = 5'(rs); t.rt = 5'(rt); t.urs = urs; t.urt = urt;
      t.rw = rw; t.aw = 5'(aw); t.br = br;
      t.e_stall = es; t.e_flush = ef; t.e_cnt = ec;
      tbl.push_back(t);
   endtask

   task automatic drive(input logic v, input int rs, input int rt, input logic urs,
                        input logic urt, input logic rw, input int aw, input logic br);
      id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs;
      id_uses_rt = urt; id_regwr = rw; id_aw = 5'(aw); branch_taken = br;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   initial begin
      // ---------------- table -------------------------------------------
      //   v rs rt urs urt rw aw br   stall flush cnt
      // back-to-back RAW on $3: three stall cycles
      add(1, 0, 0, 0, 0, 1, 3, 0,   0, 0, 0);
      add(1, 3, 0, 1, 0, 1, 4, 0,   1, 0, 0);
      add(1, 3, 0, 1, 0, 1, 4, 0,   1, 0, 1);
      add(1, 3, 0, 1, 0, 1, 4, 0,   1, 0, 2);
      add(1, 3, 0, 1, 0, 1, 4, 0,   0, 0, 3);
      add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 3);
      add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 3);
      add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 3);
      // gap of one on $5 via rt: two stall cycles
      add(1, 0, 0, 0, 0, 1, 5, 0,   0, 0, 3);
      add(1, 1, 2, 0, 0, 0, 0, 0,   0, 0, 3);
      add(1, 0, 5, 0, 1, 0, 0, 0,   1, 0, 3);
      add(1, 0, 5, 0, 1, 0, 0, 0,   1, 0, 4);
      add(1, 0, 5, 0, 1, 0, 0, 0,   0, 0, 5);
      // rs=5 but not used: no stall
      add(1, 0, 0, 0, 0, 1, 5, 0,   0, 0, 5);
      add(1, 5, 0, 0, 0, 0, 0, 0,   0, 0, 5);
      add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5);
      add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5);
      // register 0 never tracked
      add(1, 0, 0, 0, 0, 1, 0, 0,   0, 0, 5);
      add(1, 0, 0, 1, 1, 0, 0, 0,   0, 0, 5);
      // branch: two flush cycles, $7 writer under flush not allocated
      add(1, 0, 0, 0, 0, 0, 0, 1,   0, 0, 5);
      add(1, 0, 0, 0, 0, 1, 7, 0,   0, 1, 5);
      add(1, 0, 0, 0, 0, 1, 7, 0,   0, 1, 5);
      add(1, 7, 0, 1, 0, 0, 0, 0,   0, 0, 5);
      // branch during stall ignored, accepted once stall clears
      add(1, 0, 0, 0, 0, 1, 9, 0,   0, 0, 5);
      add(1, 9, 0, 1, 0, 0, 0, 1,   1, 0, 5);
      add(1, 9, 0, 1, 0, 0, 0, 1,   1, 0, 6);
      add(1, 9, 0, 1, 0, 0, 0, 1,   1, 0, 7);
      add(1, 9, 0, 1, 0, 0, 0, 1,   0, 0, 8);
      add(1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 8);
      add(1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 8);
      // branch again inside flush restarts the counter
      add(1, 0, 0, 0, 0, 0, 0, 1,   0, 0, 8);
      add(1, 0, 0, 0, 0, 0, 0, 1,   0, 1, 8);
      add(1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 8);
      add(1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 8);
      add(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 8);
      // flush masks a real hazard; the producer still completes
      add(1, 0, 0, 0, 0, 1,10, 1,   0, 0, 8);
      add(1,10, 0, 1, 0, 0, 0, 0,   0, 1, 8);
      add(1,10, 0, 1, 0, 0, 0, 0,   0, 1, 8);
      add(1,10, 0, 1, 0, 0, 0, 0,   1, 0, 8);
      add(1,10, 0, 1, 0, 0, 0, 0,   0, 0, 9);

      // ---------------- reset with hazard-like inputs -------------------
      rst = 1'b1;
      drive(1, 3, 3, 1, 1, 1, 3, 1);
      @(posedge clk); @(posedge clk); #2;
      check("rst_stall", int'(stall), 0);
      check("rst_bubble", int'(bubble), 0);
      check("rst_flush", int'(flush), 0);
      check("rst_cnt", int'(stall_cnt), 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // ---------------- table run ---------------------------------------
      foreach (tbl[i]) begin
         drive(tbl[i].v, int'(tbl[i].rs), int'(tbl[i].rt), tbl[i].urs,
               tbl[i].urt, tbl[i].rw, int'(tbl[i].aw), tbl[i].br);
         #2;
         $display("vec %0d: stall=%0b bubble=%0b flush=%0b cnt=%0d sat_cnt=%0d",
                  i, stall, bubble, flush, stall_cnt, stall_cnt2);
         check($sformatf("v%0d_stall", i), int'(stall), int'(tbl[i].e_stall));
         check($sformatf("v%0d_bubble", i), int'(bubble), int'(tbl[i].e_stall));
         check($sformatf("v%0d_flush", i), int'(flush), int'(tbl[i].e_flush));
         check($sformatf("v%0d_cnt", i), int'(stall_cnt), tbl[i].e_cnt);
         check($sformatf("v%0d_satcnt", i), int'(stall_cnt2),
               (tbl[i].e_cnt > 3) ? 3 : tbl[i].e_cnt);
         @(posedge clk); #1;
      end

      // ---------------- async reset mid-stall ---------------------------
      drive(1, 0, 0, 0, 0, 1, 3, 0);
      @(posedge clk); #1;
      drive(1, 3, 0, 1, 0, 0, 0, 0);
      #1;
      check("pre_rst_stall", int'(stall), 1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      $display("async reset mid-stall: stall=%0b flush=%0b cnt=%0d", stall, flush, stall_cnt);
      check("arst_stall", int'(stall), 0);
      check("arst_flush", int'(flush), 0);
      check("arst_cnt", int'(stall_cnt), 0);
      check("arst_satcnt", int'(stall_cnt2), 0);
      #1 rst = 1'b0;
      #1;
      check("post_rst_stall", int'(stall), 0);
      @(posedge clk); #1;
      check("post_rst_stall2", int'(stall), 0);
      check("post_rst_cnt", int'(stall_cnt), 0);

      // ---------------- async reset mid-flush ---------------------------
      drive(1, 0, 0, 0, 0, 0, 0, 1);
      @(posedge clk); #1;
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("pre_rst_flush", int'(flush), 1);
      rst = 1'b1;
      #1;
      $display("async reset mid-flush: flush=%0b", flush);
      check("arst_mid_flush", int'(flush), 0);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_flush", int'(flush), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
